// File: rtl/signed_lincomb_seq_v.sv
// Sequential signed linear combination F = KA*X +/- KB*Y, one coefficient bit per cycle.
// Optional build macro SIGNED_LINCOMB_SAT_EN: saturate o_fs on overflow instead of wrapping.

// One partial-product lane: the sign-weighted shifted multiplicand for coefficient bit n.
module signed_lincomb_term #(
    parameter int W  = 5,
    parameter int KW = 5,
    parameter int AW = W + KW + 1,
    parameter int CW = 3
) (
    input  logic [W-1:0]  x,
    input  logic [KW-1:0] k,
    input  logic [CW-1:0] n,
    input  logic          neg,
    output logic [AW-1:0] t
);
    logic signed [AW-1:0] xe;
    logic signed [AW-1:0] sh;

    always_comb begin
        xe = AW'($signed(x));
        sh = k[n] ? (xe <<< n) : '0;
        // Top coefficient bit carries weight -2^(KW-1); lane negation (subtract) folds in by XOR.
        t  = (neg ^ (n == CW'(KW - 1))) ? -sh : sh;
    end
endmodule

module signed_lincomb_seq_v #(
    parameter int W  = 5,
    parameter int KW = 5,
    parameter int OW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_sub,
    input  logic [W-1:0]  i_xs,
    input  logic [W-1:0]  i_ys,
    input  logic [KW-1:0] i_kas,
    input  logic [KW-1:0] i_kbs,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic [OW-1:0] o_fs,
    output logic          o_ovf
);
    localparam int AW = W + KW + 1;
    localparam int CW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [CW-1:0] LAST = CW'(KW - 1);
    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic          sub;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [KW-1:0] ka;
        logic [KW-1:0] kb;
    } req_t;

    state_t               state_q, state_d;
    req_t                 req;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;

    logic [NUM_LANES-1:0][W-1:0]  lane_x;
    logic [NUM_LANES-1:0][KW-1:0] lane_k;
    logic [NUM_LANES-1:0]         lane_neg;
    logic [NUM_LANES-1:0][AW-1:0] lane_t;

    logic [OW-1:0] fs_next;
    logic          ovf_next;

    // Lane 0 is KA*X, lane 1 is KB*Y (negated in subtract mode).
    assign lane_x   = {req.y, req.x};
    assign lane_k   = {req.kb, req.ka};
    assign lane_neg = {req.sub, 1'b0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        signed_lincomb_term #(.W(W), .KW(KW), .AW(AW), .CW(CW)) u_term (
            .x  (lane_x[g]),
            .k  (lane_k[g]),
            .n  (cnt),
            .neg(lane_neg[g]),
            .t  (lane_t[g])
        );
    end

    // Narrowing of the exact accumulator to the result width.
    if (OW >= AW) begin : g_wide
        assign fs_next  = OW'(acc);
        assign ovf_next = 1'b0;
    end else begin : g_narrow
        localparam logic signed [AW-1:0] FS_MAX = AW'((64'sd1 <<< (OW - 1)) - 64'sd1);
        localparam logic signed [AW-1:0] FS_MIN = ~FS_MAX;
        assign ovf_next = (acc > FS_MAX) || (acc < FS_MIN);
`ifdef SIGNED_LINCOMB_SAT_EN
        assign fs_next = !ovf_next ? acc[OW-1:0]
                       : acc[AW-1] ? {1'b1, {(OW-1){1'b0}}}
                       :             {1'b0, {(OW-1){1'b1}}};
`else
        assign fs_next = acc[OW-1:0];
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = CALC;
            CALC:    if (cnt == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req    <= '0;
            cnt    <= '0;
            acc    <= '0;
            o_done <= 1'b0;
            o_fs   <= '0;
            o_ovf  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        req <= '{sub: i_sub, x: i_xs, y: i_ys, ka: i_kas, kb: i_kbs};
                        cnt <= '0;
                        acc <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + lane_t[0] + lane_t[1];
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    o_fs   <= fs_next;
                    o_ovf  <= ovf_next;
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == CALC);
endmodule
